vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 142 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parameterised VGA raster timing generator. Produces pixel
//                strobe, x/y counters, sync pulses, active-video flag,
//                line/frame start pulses and a completed-frame counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1,
    parameter int CNT_W     = 10,
    parameter int FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               p_tick,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    // Raster geometry; each line/frame is display, front porch, sync, back porch
    localparam int H_MAX_I   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
    localparam int V_MAX_I   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1;
    localparam int CNT_MAX_I = (H_MAX_I > V_MAX_I) ? H_MAX_I : V_MAX_I;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_MAX_I);
    localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_MAX_I);
    localparam logic [CNT_W-1:0] H_ACTIVE = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_ACTIVE = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    // Refuse to elaborate when counters cannot hold the largest coordinate
    if ((CNT_W < 1) || (CNT_W > 31) || ((64'd1 << CNT_W) <= 64'(CNT_MAX_I))) begin : g_cnt_w_check
        $error("vga_timing_gen: CNT_W=%0d too narrow for max coordinate %0d", CNT_W, CNT_MAX_I);
    end

    // Pixel divider must stay in its supported range
    if ((CLK_DIV < 1) || (CLK_DIV > 16)) begin : g_clk_div_check
        $error("vga_timing_gen: CLK_DIV=%0d outside 1..16", CLK_DIV);
    end

    logic [DIV_W-1:0]   divider;
    logic [DIV_W-1:0]   divider_nxt;
    logic [CNT_W-1:0]   x_nxt;
    logic [CNT_W-1:0]   y_nxt;
    logic [FRAME_W-1:0] frame_nxt;
    logic               tick;
    logic               x_wrap;
    logic               y_wrap;
    logic               hs_active;
    logic               vs_active;
    logic               active_nxt;

    // Next-state counters: divider, then x on each pixel, y at each line end
    always_comb begin
        tick        = en && (divider == DIV_LAST);
        divider_nxt = divider;
        x_nxt       = x;
        y_nxt       = y;
        frame_nxt   = frame_count;
        x_wrap      = 1'b0;
        y_wrap      = 1'b0;
        if (en) begin
            divider_nxt = tick ? '0 : divider + DIV_W'(1);
        end
        if (tick) begin
            if (x == H_MAX) begin
                x_nxt  = '0;
                x_wrap = 1'b1;
                if (y == V_MAX) begin
                    y_nxt     = '0;
                    y_wrap    = 1'b1;
                    frame_nxt = frame_count + FRAME_W'(1);
                end else begin
                    y_nxt = y + CNT_W'(1);
                end
            end else begin
                x_nxt = x + CNT_W'(1);
            end
        end
    end

    // Decode syncs and active area from next-state coordinates so they
    // register on the same edge as x/y
    always_comb begin
        hs_active  = (x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST);
        vs_active  = (y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST);
        active_nxt = (x_nxt < H_ACTIVE) && (y_nxt < V_ACTIVE);
    end

    // State and output registers; reset returns to (0,0) silently
    always_ff @(posedge clk) begin
        if (!reset) begin
            divider     <= '0;
            x           <= '0;
            y           <= '0;
            frame_count <= '0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            video_on    <= 1'b1;
            p_tick      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            divider     <= divider_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            frame_count <= frame_nxt;
            hsync       <= hs_active ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= vs_active ? VSYNC_POL : ~VSYNC_POL;
            video_on    <= active_nxt;
            p_tick      <= tick;
            line_start  <= x_wrap;
            frame_start <= x_wrap && y_wrap;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench for vga_timing_gen. Two instances: a
//                default-width line with a short frame (A) and a tiny raster
//                with CLK_DIV=1, inverted syncs and 2-bit frame counter (B).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, en_a, reset_b, en_b;
    logic       hsync_a, vsync_a, video_on_a, p_tick_a, line_start_a, frame_start_a;
    logic       hsync_b, vsync_b, video_on_b, p_tick_b, line_start_b, frame_start_b;
    logic [9:0] x_a, y_a;
    logic [7:0] fc_a;
    logic [3:0] x_b, y_b;
    logic [1:0] fc_b;

    vga_timing_gen #(
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut_a (
        .clk(clk), .reset(reset_a), .en(en_a),
        .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a), .p_tick(p_tick_a),
        .x(x_a), .y(y_a), .line_start(line_start_a), .frame_start(frame_start_a),
        .frame_count(fc_a)
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(1), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(4), .FRAME_W(2)
    ) dut_b (
        .clk(clk), .reset(reset_b), .en(en_b),
        .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b), .p_tick(p_tick_b),
        .x(x_b), .y(y_b), .line_start(line_start_b), .frame_start(frame_start_b),
        .frame_count(fc_b)
    );

    typedef struct {
        int hd, hf, hs, hb, vd, vf, vs, vb, dv, fw;
        bit hp, vp;
    } cfg_t;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] fc;
        logic        hs, vs, von, pt, ls, fs;
    } obs_t;

    typedef struct {
        bit rst, en;
        int ncyc;
        int x, y;
        bit hs, vs, von, pt;
        int fc;
    } vec_t;

    cfg_t cfg_a, cfg_b;
    int   e_a = 0, e_b = 0;      // enabled clocks since reset
    bit   pt_a = 0, pt_b = 0;    // expected pixel strobe after this edge
    int   cyc = 0;
    int   n_checks = 0, n_pass = 0;

    // Reference: everything follows from the count of pixels since reset
    function automatic obs_t predict(cfg_t c, int e, bit pt);
        obs_t o;
        int ht, vt, n, px, py;
        ht = c.hd + c.hf + c.hs + c.hb;
        vt = c.vd + c.vf + c.vs + c.vb;
        n  = e / c.dv;
        px = n % ht;
        py = (n / ht) % vt;
        o.x   = px;
        o.y   = py;
        o.fc  = (n / (ht * vt)) % (1 << c.fw);
        o.hs  = (px >= c.hd + c.hf && px < c.hd + c.hf + c.hs) ? c.hp : ~c.hp;
        o.vs  = (py >= c.vd + c.vf && py < c.vd + c.vf + c.vs) ? c.vp : ~c.vp;
        o.von = (px < c.hd) && (py < c.vd);
        o.pt  = pt;
        o.ls  = pt && (px == 0);
        o.fs  = pt && (px == 0) && (py == 0);
        return o;
    endfunction

    function automatic obs_t obs_a();
        obs_t o;
        o = '{32'(x_a), 32'(y_a), 32'(fc_a), hsync_a, vsync_a, video_on_a,
              p_tick_a, line_start_a, frame_start_a};
        return o;
    endfunction

    function automatic obs_t obs_b();
        obs_t o;
        o = '{32'(x_b), 32'(y_b), 32'(fc_b), hsync_b, vsync_b, video_on_b,
              p_tick_b, line_start_b, frame_start_b};
        return o;
    endfunction

    task automatic check(string name, int got, int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    endtask

    task automatic check_obs(string name, obs_t got, obs_t want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s cycle %0d: got x=%0d y=%0d fc=%0d hs/vs/von/pt/ls/fs=%b%b%b%b%b%b, want x=%0d y=%0d fc=%0d hs/vs/von/pt/ls/fs=%b%b%b%b%b%b",
                      name, cyc, got.x, got.y, got.fc, got.hs, got.vs, got.von, got.pt, got.ls, got.fs,
                      want.x, want.y, want.fc, want.hs, want.vs, want.von, want.pt, want.ls, want.fs);
    endtask

    // One clock: advance both models with the inputs seen at the edge, then compare
    task automatic step();
        @(posedge clk);
        cyc++;
        if (!reset_a) begin e_a = 0; pt_a = 0; end
        else if (en_a) begin e_a++; pt_a = ((e_a % cfg_a.dv) == 0); end
        else pt_a = 0;
        if (!reset_b) begin e_b = 0; pt_b = 0; end
        else if (en_b) begin e_b++; pt_b = ((e_b % cfg_b.dv) == 0); end
        else pt_b = 0;
        #1;
        check_obs("model_a", obs_a(), predict(cfg_a, e_a, pt_a));
        check_obs("model_b", obs_b(), predict(cfg_b, e_b, pt_b));
    endtask

    initial begin
        vec_t vec[10];
        int   exp_fc[5];
        int   k, cnt, mn, mx, t0, prev_x, steps;
        int   fs_cyc[5];
        int   ls_cyc[2];
        bit   ok, frozen;
        logic [9:0] hold_x, hold_y;
        logic       hold_hs;
        logic [1:0] prev_fc;

        cfg_a = '{hd:640, hf:16, hs:96, hb:48, vd:4, vf:1, vs:2, vb:1, dv:2, fw:8, hp:1'b1, vp:1'b1};
        cfg_b = '{hd:8, hf:2, hs:2, hb:2, vd:4, vf:1, vs:1, vb:1, dv:1, fw:2, hp:1'b0, vp:1'b0};

        // rst, en, cycles, x, y, hs, vs, von, pt, fc  (instance B)
        vec[0] = '{1'b0, 1'b1, 2,  0,  0, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        vec[1] = '{1'b1, 1'b1, 1,  1,  0, 1'b1, 1'b1, 1'b1, 1'b1, 0};
        vec[2] = '{1'b1, 1'b1, 9,  10, 0, 1'b0, 1'b1, 1'b0, 1'b1, 0};
        vec[3] = '{1'b1, 1'b1, 1,  11, 0, 1'b0, 1'b1, 1'b0, 1'b1, 0};
        vec[4] = '{1'b1, 1'b1, 1,  12, 0, 1'b1, 1'b1, 1'b0, 1'b1, 0};
        vec[5] = '{1'b1, 1'b1, 2,  0,  1, 1'b1, 1'b1, 1'b1, 1'b1, 0};
        vec[6] = '{1'b1, 1'b0, 5,  0,  1, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        vec[7] = '{1'b1, 1'b1, 42, 0,  4, 1'b1, 1'b1, 1'b0, 1'b1, 0};
        vec[8] = '{1'b1, 1'b1, 14, 0,  5, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        vec[9] = '{1'b1, 1'b1, 28, 0,  0, 1'b1, 1'b1, 1'b1, 1'b1, 1};
        exp_fc = '{1, 2, 3, 0, 1};

        reset_a = 1'b0; en_a = 1'b0;
        reset_b = 1'b0; en_b = 1'b1;

        // ---- B: table-driven vectors ----
        for (int i = 0; i < 10; i++) begin
            reset_b = vec[i].rst;
            en_b    = vec[i].en;
            for (int c = 0; c < vec[i].ncyc; c++) step();
            check($sformatf("vec%0d_x", i), int'(x_b), vec[i].x);
            check($sformatf("vec%0d_y", i), int'(y_b), vec[i].y);
            check($sformatf("vec%0d_flags", i), int'({hsync_b, vsync_b, video_on_b, p_tick_b}),
                  int'({vec[i].hs, vec[i].vs, vec[i].von, vec[i].pt}));
            check($sformatf("vec%0d_fc", i), int'(fc_b), vec[i].fc);
        end

        // ---- B: five frames with a 2-bit frame counter ----
        reset_b = 1'b0; en_b = 1'b1;
        step();
        reset_b = 1'b1;
        k = 0; cnt = 0; prev_fc = fc_b;
        for (int c = 0; c < 700 && k < 5; c++) begin
            step();
            if (line_start_b && cnt < 2) begin ls_cyc[cnt] = cyc; cnt++; end
            if (frame_start_b) begin
                check($sformatf("b_fc_seq%0d", k), int'(fc_b), exp_fc[k]);
                fs_cyc[k] = cyc;
                k++;
            end
            if ((fc_b != prev_fc) || frame_start_b)
                check("b_fc_change_with_fs", int'(fc_b != prev_fc), int'(frame_start_b));
            prev_fc = fc_b;
        end
        check("b_five_frames_seen", k, 5);
        if (k == 5) check("b_frame_period", fs_cyc[4] - fs_cyc[3], 98);
        if (cnt == 2) check("b_line_period", ls_cyc[1] - ls_cyc[0], 14);

        // ---- A: reset state and divider phase ----
        reset_a = 1'b0; en_a = 1'b1;
        step();
        check("a_reset_state", int'({x_a, y_a, hsync_a, vsync_a, video_on_a, p_tick_a, line_start_a, frame_start_a}),
              int'({10'd0, 10'd0, 6'b001000}));
        reset_a = 1'b1;
        step();
        check("a_first_clk_no_tick", int'(p_tick_a), 0);
        step();
        check("a_second_clk_tick", int'(p_tick_a), 1);
        check("a_first_pixel_x", int'(x_a), 1);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin step(); cnt += int'(p_tick_a); end
        check("a_tick_every_2nd", cnt, 10);

        // ---- A: line wrap and hsync window ----
        ok = 0; prev_x = int'(x_a);
        for (int c = 0; c < 2000 && !ok; c++) begin
            step();
            if (line_start_a) ok = 1; else prev_x = int'(x_a);
        end
        check("a_line_wrap_seen", int'(ok), 1);
        check("a_x_before_wrap", prev_x, 799);
        cnt = 0; mn = 9999; mx = -1;
        for (int c = 0; c < 1600; c++) begin
            step();
            if (p_tick_a && hsync_a) begin
                cnt++;
                if (int'(x_a) < mn) mn = int'(x_a);
                if (int'(x_a) > mx) mx = int'(x_a);
            end
        end
        check("a_hsync_count", cnt, 96);
        check("a_hsync_first", mn, 656);
        check("a_hsync_last", mx, 751);

        // ---- A: freeze for 37 clocks at x=300 ----
        ok = 0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            step();
            if (p_tick_a && x_a == 10'd300) ok = 1;
        end
        check("a_reach_x300", int'(ok), 1);
        en_a = 1'b0;
        hold_x = x_a; hold_y = y_a; hold_hs = hsync_a;
        frozen = 1;
        for (int c = 0; c < 37; c++) begin
            step();
            if (x_a != hold_x || y_a != hold_y || hsync_a != hold_hs ||
                p_tick_a || line_start_a || frame_start_a) frozen = 0;
        end
        check("a_frozen", int'(frozen), 1);
        en_a = 1'b1;
        steps = 0; ok = 0;
        for (int c = 0; c < 6 && !ok; c++) begin
            step();
            steps++;
            if (p_tick_a) ok = 1;
        end
        check("a_resume_latency", steps, 2);
        check("a_resume_x", int'(x_a), 301);

        // ---- A: full frame timing and vsync rows ----
        ok = 0;
        for (int c = 0; c < 20000 && !ok; c++) begin step(); if (frame_start_a) ok = 1; end
        check("a_first_frame_seen", int'(ok), 1);
        check("a_fc_after_first_frame", int'(fc_a), 1);
        t0 = cyc; ok = 0; mn = 9999; mx = -1;
        for (int c = 0; c < 20000 && !ok; c++) begin
            step();
            if (vsync_a) begin
                if (int'(y_a) < mn) mn = int'(y_a);
                if (int'(y_a) > mx) mx = int'(y_a);
            end
            if (frame_start_a) ok = 1;
        end
        check("a_second_frame_seen", int'(ok), 1);
        check("a_frame_period", cyc - t0, 12800);
        check("a_vsync_first_row", mn, 5);
        check("a_vsync_last_row", mx, 6);
        check("a_fc_after_second_frame", int'(fc_a), 2);

        // ---- A: reset while both syncs are active ----
        ok = 0;
        for (int c = 0; c < 20000 && !ok; c++) begin
            step();
            if (x_a == 10'd700 && y_a == 10'd6) ok = 1;
        end
        check("a_reach_700_6", int'(ok), 1);
        check("a_both_sync_active", int'({hsync_a, vsync_a}), 3);
        reset_a = 1'b0;
        step();
        check("a_reset_mid_sync", int'({x_a, y_a, hsync_a, vsync_a, video_on_a, line_start_a, frame_start_a}),
              int'({10'd0, 10'd0, 5'b00100}));
        reset_a = 1'b1;

        // ---- Randomised enable and reset on both instances ----
        for (int c = 0; c < 6000; c++) begin
            en_a    = ($urandom_range(0, 7) != 0);
            en_b    = ($urandom_range(0, 5) != 0);
            reset_a = ($urandom_range(0, 999) != 0);
            reset_b = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
